// File: rtl/pipe_arb_pkg.sv
// Shared types and helpers for the round-robin pipe arbiter.
package pipe_arb_pkg;

  localparam int unsigned DefaultN = 4;
  localparam int unsigned MaxN     = 32;
  localparam int unsigned MaxIdxW  = 5;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  function automatic rr_pick_t rr_select(input logic [MaxN-1:0] valid,
                                         input int unsigned n,
                                         input int unsigned ptr);
    rr_pick_t    pick;
    int unsigned j;
    pick = '0;
    for (int unsigned k = 0; k < MaxN; k++) begin
      if (k < n && !pick.found) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (valid[j[MaxIdxW-1:0]]) begin
          pick.found = 1'b1;
          pick.idx   = j[MaxIdxW-1:0];
        end
      end
    end
    return pick;
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pipe.sv
// Single registered valid/ready stage with flush; flush hides and drops the held beat.
module pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             pin_valid,
  output logic             pin_ready,
  input  logic [WIDTH-1:0] pin_data,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [WIDTH-1:0] pout_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign pin_ready  = ~valid_q | pout_ready | flush;
  assign pout_valid = valid_q & ~flush;
  assign pout_data  = data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (pin_valid && pin_ready) begin
      valid_q <= 1'b1;
      data_q  <= pin_data;
    end else if (pin_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_arb.sv
// Round-robin arbiter sharing one pipe stage among N requesters.
// Define PIPE_ARB_LOCK_EN to hold the grant on one source until its last beat.
module pipe_arb
  import pipe_arb_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDX_W-1:0]     out_src
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             stage_ready;
  logic             accept;
  logic [WIDTH-1:0] req_words [N];
  rr_pick_t         pick;
  logic             unused_pick_hi;

`ifdef PIPE_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_src_q, lock_src_d;
`else
  logic             unused_last;
  assign unused_last = ^req_last;
`endif

  assign unused_pick_hi = ^pick.idx[MaxIdxW-1:IDX_W];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      req_words[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    pick   = rr_select(MaxN'(req_valid), N, 32'(ptr_q));
    winner = pick.idx[IDX_W-1:0];
    found  = pick.found;
`ifdef PIPE_ARB_LOCK_EN
    // A locked packet owns the stage even while its source idles.
    if (lock_q) begin
      winner = lock_src_q;
      found  = req_valid[lock_src_q];
    end
`endif
  end

  assign accept    = found & stage_ready & ~flush & ~reset;
  assign req_ready = accept ? (N'(1) << winner) : '0;

  always_comb begin
    ptr_d = ptr_q;
`ifdef PIPE_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (flush) begin
      lock_d = 1'b0;
    end else if (accept) begin
      if (req_last[winner]) begin
        lock_d = 1'b0;
        ptr_d  = IDX_W'(ptr_inc(32'(winner), N));
      end else begin
        lock_d     = 1'b1;
        lock_src_d = winner;
      end
    end
`else
    if (accept) ptr_d = IDX_W'(ptr_inc(32'(winner), N));
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= '0;
`ifdef PIPE_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_src_q <= '0;
`endif
    end else begin
      ptr_q      <= ptr_d;
`ifdef PIPE_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
`endif
    end
  end

  pipe #(
    .WIDTH(WIDTH + IDX_W)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .pin_valid (accept),
    .pin_ready (stage_ready),
    .pin_data  ({winner, req_words[winner]}),
    .pout_valid(out_valid),
    .pout_ready(out_ready),
    .pout_data ({out_src, out_data})
  );

endmodule

// File: tb/tb_pipe_arb.sv
// Randomized bench for pipe_arb against a transaction-level reference model.
module tb_pipe_arb;

  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int IDX_W = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               flush;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [IDX_W-1:0]   out_src;

  pipe_arb #(
    .N    (N),
    .WIDTH(WIDTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_last (req_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               m_ptr;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  bit               m_lock;
  int               m_lock_src;
  int               dir_src;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_winner();
`ifdef PIPE_ARB_LOCK_EN
    if (m_lock) return req_valid[m_lock_src] ? m_lock_src : -1;
`endif
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Inputs are already driven; sample at negedge, advance model, return after next posedge.
  task automatic step();
    int         w;
    bit         sready;
    bit         acc;
    logic [N-1:0] exp_ready;
    @(negedge clock);
    sready    = !m_valid || out_ready || flush;
    w         = pick_winner();
    acc       = (w >= 0) && sready && !flush && !reset;
    exp_ready = acc ? (N'(1) << w) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(m_valid && !flush));
    check("out_data", 64'(out_data), 64'(m_data));
    check("out_src", 64'(out_src), 64'(m_src));
    if (dir_src >= 0) begin
      check("rotation_src", 64'(out_src), 64'(dir_src));
      check("rotation_valid", 64'(out_valid), 64'd1);
    end
    if (reset) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_lock = 0; m_lock_src = 0;
    end else if (flush) begin
      m_valid = 0;
      m_lock  = 0;
    end else if (acc) begin
      m_valid = 1;
      m_data  = req_data[w*WIDTH +: WIDTH];
      m_src   = w;
`ifdef PIPE_ARB_LOCK_EN
      if (req_last[w]) begin
        m_lock = 0;
        m_ptr  = (w + 1) % N;
      end else begin
        m_lock     = 1;
        m_lock_src = w;
      end
`else
      m_ptr = (w + 1) % N;
`endif
    end else if (sready) begin
      m_valid = 0;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    dir_src   = -1;
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_lock = 0; m_lock_src = 0;

    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();

    // All requesters valid, downstream always ready: sources rotate 0,1,2,3,...
    req_valid = '1;
    req_last  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req_data = {$urandom, $urandom};
      dir_src  = (i == 0) ? -1 : (i - 1) % N;
      step();
    end
    dir_src = -1;

    // Lone requester 2 with a stalled downstream, then release.
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[2*WIDTH +: WIDTH] = 16'hBEEF;
    out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    req_valid = '0;
    repeat (2) step();

    // Flush on a full stage with requester 1 pending.
    req_valid = 4'b0010;
    out_ready = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 2000; i++) begin
      req_valid = N'($urandom);
      req_data  = {$urandom, $urandom};
      for (int r = 0; r < N; r++) req_last[r] = ($urandom_range(2) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      reset     = ($urandom_range(99) == 0);
      step();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_arb.md
# pipe_arb

Round-robin arbiter that shares one registered valid/ready pipe stage among N requesters. Each cycle it picks one valid requester, hands that requester's beat to the shared stage, and forwards it downstream with the winning source index. It sits in front of shared datapath resources in the cache, such as a shared response or refill channel. It honours the same flush semantics as the single pipe stage it wraps.

## Interface
Parameters:
- N, 4, number of requesters (N >= 2)
- WIDTH, 16, payload width per requester
- IDX_W, $clog2(N), width of source index (derived; do not override)

Ports:
- clock  in  1  clock, rising-edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  drop stage contents and inhibit grants this cycle
- req_valid  in  N  per-requester valid
- req_ready  out  N  per-requester ready (one-hot or zero)
- req_data  in  N*WIDTH  requester i at bits [i*WIDTH +: WIDTH]
- req_last  in  N  last beat of packet (used only with lock feature)
- out_valid  out  1  stage holds a beat and flush is low
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  registered payload
- out_src  out  IDX_W  registered index of winning requester

## Operation
- stage_ready = ~valid_q | out_ready | flush.
- Winner: first i with req_valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wraps mod N).
- req_ready[winner] = stage_ready & ~flush. All other req_ready bits are 0.
- Accept = req_valid[winner] & req_ready[winner]. On accept, the stage captures {winner, req_data[winner]} and valid_q <= 1.
- Pointer on accept: ptr <= (winner == N-1) ? 0 : winner+1. Result: the last winner has lowest priority next time.
- No accept and stage_ready: valid_q <= 0.
- No accept and ~stage_ready: stage holds; data is stable while out_valid & ~out_ready.
- Flush:
  - out_valid = 0 combinationally.
  - No grant; valid_q <= 0.
  - ptr unchanged; lock (if built) cleared.
- Reset values: valid_q=0, out_valid=0, out_data=0, out_src=0, ptr=0, req_ready=0 during reset, lock=0.

## Timing
- Latency: accept in cycle t gives out_valid in t+1.
- Throughput: 1 beat/cycle when out_ready is held high.
- Combinational paths:
  - req_valid -> req_ready
  - out_ready -> req_ready
  - flush -> req_ready
  - flush -> out_valid
- No combinational path req_data -> out_data.
- Simultaneous out_ready and new accept: the old beat leaves and the new beat is loaded in the same edge; no bubble.
- All req_valid low: no state change except valid_q draining.
- Reset mid-stream: a beat in flight is lost; the next cycle after reset deasserts, arbitration starts from ptr=0.

## Configuration
- PIPE_ARB_LOCK_EN defined (packet lock):
  - An accepted beat with req_last=0 sets lock and lock_src=winner.
  - While locked, only lock_src may be granted. Other requesters get ready=0 even if lock_src is idle; bubbles are allowed.
  - An accepted beat with req_last=1 clears lock and advances ptr.
  - ptr advances only on last beats.
  - Flush or reset clears lock.
- Macro undefined: req_last is ignored, every beat re-arbitrates, and there are no lock registers.

## Structure
- Package pipe_arb_pkg holds:
  - the rotate-priority-select function (returns winner index and found flag)
  - the ptr-increment-with-wrap function
  - a default N localparam
- One sub-module: the existing `pipe` stage, instantiated with WIDTH+IDX_W. Its input side is driven by the arbiter with pin_valid = accept and flush passed through.
- Arbiter logic (ptr, lock, grant) lives in pipe_arb itself.

## Test plan
- Reset, then all requesters idle -> out_valid=0, out_data=0, out_src=0, req_ready=0 every cycle.
- N=4, all req_valid=1, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; one req_ready bit per cycle.
- Only req 2 valid with data 0xBEEF, out_ready=0 for 3 cycles -> out_valid=1 from cycle t+1, out_data=0xBEEF held stable, req_ready[2]=0 while stalled; out_ready=1 -> beat leaves.
- Stage full, flush=1 for one cycle with req 1 valid -> out_valid=0 that cycle, req_ready=0, next cycle out_valid=0; ptr unchanged, so req 1 wins afterwards.
- Pointer wrap: req 3 wins, then req 0 and req 3 both valid -> req 0 granted next.
- PIPE_ARB_LOCK_EN: req 1 sends 3 beats (last on third) while req 0 is continuously valid -> out_src=1,1,1 then 0. Without the macro -> out_src alternates 1,0,1,0.
